// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - push-side and UART-side signal bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  // Producer side
  logic [7:0]          i_data;
  logic                i_valid;
  logic                i_flush;
  logic                o_full;
  logic                o_empty;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_overflow;
  // UART side
  logic [7:0]          o_data;
  logic                o_valid;
  logic                i_busy;

  modport slave (
    input  i_data, i_valid, i_flush, i_busy,
    output o_full, o_empty, o_count, o_overflow, o_data, o_valid
  );

  modport master (
    output i_data, i_valid, i_flush, i_busy,
    input  o_full, o_empty, o_count, o_overflow, o_data, o_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into a UART transmitter via valid/busy edge handshake
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          clk_x4,
  input  logic          rst_x,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_dly_q;

  logic full, empty, busy_rise, busy_fall, push, pop;

  // Status flags come from the registered count, so a pop this cycle
  // does not open room for a push in the same cycle.
  assign full      = (count_q == CNT_DEPTH);
  assign empty     = (count_q == '0);
  assign busy_rise = bus.i_busy & ~busy_dly_q;
  assign busy_fall = ~bus.i_busy & busy_dly_q;
  // A flush discards the same-cycle push as well as the queue.
  assign push      = bus.i_valid & ~full & ~bus.i_flush;

  // Drain FSM: loads a byte when the UART is ready and tracks the busy handshake
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !bus.i_flush) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (busy_rise) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (busy_fall) begin
          // Chain the next byte on the very edge the frame ends.
          if (!empty && !bus.i_flush) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Queue bookkeeping: pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.i_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
        count_d = count_q - CNT_ONE;
      end
      if (bus.i_valid && full) overflow_d = 1'b1;
    end
  end

  // Storage array; contents need no reset because pointers gate every read
  always_ff @(posedge clk_x4) begin
    if (rst_x && push) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge clk_x4) begin
    if (!rst_x) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_dly_q <= bus.i_busy;
    end
  end

  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a behavioural UART model
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk_x4 (clk),
    .rst_x  (rst_x),
    .bus    (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         uart_en   = 1'b0;
  bit         b2b_en    = 1'b0;
  bit         chk_next  = 1'b0;
  bit         exp_ovf   = 1'b0;
  int         rise_dly  = 3;
  int         frame_len = 8;
  int         ucnt      = 0;

  // UART model: raises busy rise_dly cycles after seeing valid, captures the byte,
  // holds busy for frame_len cycles. Optionally checks the zero-gap reload.
  always @(negedge clk) begin
    if (chk_next) begin
      chk_next = 1'b0;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp_q[rx_q.size()]) begin
        errors++;
        $display("FAIL b2b_reload: o_valid=%0b o_data=%02h, required 1 and %02h",
                 bus.o_valid, bus.o_data, exp_q[rx_q.size()]);
      end
    end
    if (!uart_en) begin
      bus.i_busy = 1'b0;
      ucnt       = 0;
    end else if (!bus.i_busy) begin
      if (bus.o_valid === 1'b1) begin
        if (ucnt >= rise_dly - 1) begin
          bus.i_busy = 1'b1;
          rx_q.push_back(bus.o_data);
          ucnt = 0;
        end else begin
          ucnt++;
        end
      end
    end else if (ucnt >= frame_len - 1) begin
      bus.i_busy = 1'b0;
      ucnt       = 0;
      if (b2b_en && exp_q.size() > rx_q.size()) chk_next = 1'b1;
    end else begin
      ucnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    bus.i_data  = b;
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic do_reset();
    uart_en     = 1'b0;
    b2b_en      = 1'b0;
    rst_x       = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_data  = 8'($urandom);
    tick();
    tick();
    rst_x       = 1'b1;
    bus.i_valid = 1'b0;
    exp_ovf     = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  // Wait until every expected byte has been captured, then let the last frame end.
  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (rx_q.size() < exp_q.size() && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (rx_q.size() < exp_q.size()) begin
      errors++;
      $display("FAIL drain_timeout: received %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end
    repeat (frame_len + 4) tick();
  endtask

  task automatic wait_space(input int need);
    int n;
    n = 0;
    while (int'(bus.o_count) > DEPTH - need && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL space_timeout: o_count=%0d, required <= %0d", bus.o_count, DEPTH - need);
    end
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== 5'd0 || bus.o_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_count: empty=%0b count=%0d full=%0b, required 1 0 0",
               bus.o_empty, bus.o_count, bus.o_full);
    end
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_overflow !== 1'b0 || bus.o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: valid=%0b ovf=%0b data=%02h, required 0 0 00",
               bus.o_valid, bus.o_overflow, bus.o_data);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    uart_en = 1'b1; rise_dly = 3; frame_len = 8;
    push_byte(8'h48, 1'b1);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 5'd1) begin
      errors++;
      $display("FAIL single_push: valid=%0b count=%0d, required 0 1", bus.o_valid, bus.o_count);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h48 || bus.o_count !== 5'd0) begin
      errors++;
      $display("FAIL single_load: valid=%0b data=%02h count=%0d, required 1 48 0",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    n = 0;
    while (rx_q.size() == 0 && n < 20) begin tick(); n++; end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drop: valid=%0b, required 0", bus.o_valid);
    end
    wait_drain(50);
    compare_stream("single");
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 8'h48) begin
      errors++;
      $display("FAIL single_idle: empty=%0b valid=%0b data=%02h, required 1 0 48",
               bus.o_empty, bus.o_valid, bus.o_data);
    end
  endtask

  task automatic test_string();
    do_reset();
    uart_en = 1'b1; rise_dly = 3; frame_len = 8; b2b_en = 1'b1;
    push_byte(8'h48, 1'b1);
    push_byte(8'h45, 1'b1);
    push_byte(8'h4c, 1'b1);
    push_byte(8'h4f, 1'b1);
    checks++;
    if (bus.o_count !== 5'd3 || bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL string_count: count=%0d valid=%0b, required 3 1", bus.o_count, bus.o_valid);
    end
    wait_drain(200);
    compare_stream("string");
    b2b_en = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) push_byte(8'($urandom), 1'b1);
    checks++;
    if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16 || bus.o_valid !== 1'b1 || bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: full=%0b count=%0d valid=%0b ovf=%0b, required 1 16 1 0",
               bus.o_full, bus.o_count, bus.o_valid, bus.o_overflow);
    end
    push_byte(8'($urandom), 1'b0);
    exp_ovf = 1'b1;
    checks++;
    if (bus.o_overflow !== 1'b1 || bus.o_count !== 5'd16) begin
      errors++;
      $display("FAIL ovf_drop: ovf=%0b count=%0d, required 1 16", bus.o_overflow, bus.o_count);
    end
    uart_en = 1'b1; rise_dly = 2; frame_len = 6;
    wait_drain(600);
    repeat (30) tick();
    compare_stream("ovf");
  endtask

  // Runs right after the overflow test so the sticky flag is expected to stay set.
  task automatic test_flush_mid();
    logic [7:0] first;
    int         n;
    bit         saw_valid;
    rx_q.delete(); exp_q.delete();
    uart_en = 1'b1; rise_dly = 3; frame_len = 8;
    first = 8'($urandom);
    push_byte(first, 1'b1);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0);
    n = 0;
    while (rx_q.size() == 0 && n < 20) begin tick(); n++; end
    tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    checks++;
    if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1 || bus.o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL flush_mid_state: count=%0d empty=%0b ovf=%0b, required 0 1 %0b",
               bus.o_count, bus.o_empty, bus.o_overflow, exp_ovf);
    end
    saw_valid = 1'b0;
    repeat (40) begin
      tick();
      if (bus.o_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL flush_mid_quiet: o_valid seen 1 after flush, required 0");
    end
    compare_stream("flush_mid");
  endtask

  task automatic test_flush_full();
    logic [7:0] first;
    do_reset();
    first = 8'($urandom);
    push_byte(first, 1'b1);
    for (int i = 0; i < 16; i++) push_byte(8'($urandom), 1'b0);
    bus.i_flush = 1'b1;
    push_byte(8'($urandom), 1'b0);
    bus.i_flush = 1'b0;
    checks++;
    if (bus.o_full !== 1'b0 || bus.o_count !== 5'd0 || bus.o_overflow !== 1'b0 || bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: full=%0b count=%0d ovf=%0b valid=%0b, required 0 0 0 1",
               bus.o_full, bus.o_count, bus.o_overflow, bus.o_valid);
    end
    uart_en = 1'b1; rise_dly = 2; frame_len = 5;
    repeat (30) tick();
    compare_stream("flush_full");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_byte(8'h5a, 1'b0);
    tick();
    rst_x = 1'b0;
    tick();
    rst_x = 1'b1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_empty !== 1'b1 || bus.o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b empty=%0b data=%02h, required 0 1 00",
               bus.o_valid, bus.o_empty, bus.o_data);
    end
  endtask

  task automatic test_wrap();
    int v, burst;
    do_reset();
    uart_en = 1'b1; rise_dly = int'($urandom_range(1, 4)); frame_len = int'($urandom_range(2, 8));
    b2b_en = 1'b1;
    v = 0;
    while (v < 40) begin
      burst = int'($urandom_range(1, 8));
      if (v + burst > 40) burst = 40 - v;
      wait_space(burst);
      for (int i = 0; i < burst; i++) begin
        push_byte(8'(v), 1'b1);
        v++;
      end
      repeat ($urandom_range(0, 12)) tick();
    end
    wait_drain(2000);
    compare_stream("wrap");
    checks++;
    if (bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf: ovf=%0b, required 0", bus.o_overflow);
    end
    b2b_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    uart_en = 1'b1; rise_dly = int'($urandom_range(1, 4)); frame_len = int'($urandom_range(2, 10));
    b2b_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wait_space(1);
      push_byte(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain(3000);
    compare_stream("random");
    checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_empty !== 1'b1) begin
      errors++;
      $display("FAIL random_end: ovf=%0b empty=%0b, required 0 1", bus.o_overflow, bus.o_empty);
    end
    b2b_en = 1'b0;
  endtask

  initial begin
    bus.i_data  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    test_reset();
    test_single();
    test_string();
    test_overflow();
    test_flush_mid();
    test_flush_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
